// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the instruction/data memory request arbiter.
// The optional round-robin tie-break is selected with ARB_ROUND_ROBIN_EN.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Instruction fetches are always full-word reads.
  localparam logic [1:0] FETCH_SIZE = 2'd3;

endpackage

// File: rtl/mem_req_arbiter_arb_pick2.sv
// Two-way grant selection between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise data wins.
module arb_pick2
  import mem_req_arbiter_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

  assign grant = req_i | req_d;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    owner = OWN_I;
    if (req_i && req_d) begin
      owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      owner = OWN_D;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    owner = OWN_I;
    if (req_d) begin
      owner = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of data-first.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              i_data_ok,
  output logic              d_data_ok,
  output logic              i_stall,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  arb_state_t state;
  logic       owner;
  logic       last_owner;
  logic       grant;
  logic       grant_owner;

  // A requester whose completion is pulsing this cycle is not pending again yet;
  // its request line is still high until the pipeline sees the pulse.
  assign i_stall   = i_req & ~i_data_ok;
  assign d_stall   = d_req & ~d_data_ok;
  assign dbg_state = state;

  arb_pick2 u_pick (
    .req_i      (i_stall),
    .req_d      (d_stall),
    .last_owner (last_owner),
    .grant      (grant),
    .owner      (grant_owner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_I;
    end else if (state == IDLE && grant) begin
      last_owner <= grant_owner;
    end
  end
`else
  assign last_owner = OWN_I;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_data_ok <= 1'b0;
      d_data_ok <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      i_data_ok <= 1'b0;
      d_data_ok <= 1'b0;
      case (state)
        IDLE: begin
          // Memory responses arriving here belong to no transaction and are dropped.
          if (grant) begin
            owner   <= grant_owner;
            mem_req <= 1'b1;
            state   <= ADDR;
            if (grant_owner == OWN_D) begin
              mem_wr    <= d_wr;
              mem_size  <= d_size;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_wr    <= 1'b0;
              mem_size  <= FETCH_SIZE;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        ADDR: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            state <= IDLE;
            if (owner == OWN_D) begin
              d_data_ok <= 1'b1;
              if (!mem_wr) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              i_data_ok <= 1'b1;
              i_rdata   <= mem_rdata;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_req  input  1  instruction fetch read request; held until i_data_ok.
REQ-006 SHALL have port i_addr  input  ADDR_W  fetch address.
REQ-007 SHALL have port d_req  input  1  data request; held until d_data_ok.
REQ-008 SHALL have port d_wr  input  1  1 = store, 0 = load.
REQ-009 SHALL have port d_size  input  2  byte count minus 1 (0, 1 or 3).
REQ-010 SHALL have port d_addr  input  ADDR_W  data address.
REQ-011 SHALL have port d_wdata  input  DATA_W  store data.
REQ-012 SHALL have port i_rdata / d_rdata  output  DATA_W each  returned read data.
REQ-013 SHALL have port i_data_ok / d_data_ok  output  1 each  one-cycle completion pulse.
REQ-014 SHALL have port i_stall / d_stall  output  1 each  stall requests to the pipeline hazard logic.
REQ-015 SHALL have port mem_req, mem_wr  output  1 each; mem_size  output  2; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; this is the shared memory-side request.
REQ-016 SHALL have port mem_addr_ok, mem_data_ok  input  1 each; mem_rdata  input  DATA_W; this is the memory-side response.

Function
REQ-017 SHALL use FSM states IDLE, ADDR, DATA with exactly one outstanding transaction.
REQ-018 IDLE: on any pending request, grant one (REQ-026), latch its addr/wr/size/wdata and owner into registers, go to ADDR.
REQ-019 ADDR: mem_req=1 driven from latched registers only; on mem_addr_ok go to DATA; mem_req=0 in every other state.
REQ-020 DATA: on mem_data_ok pulse the owner's *_data_ok for exactly that cycle, register mem_rdata into the owner's *_rdata, return to IDLE.
REQ-021 Fetch requests SHALL set mem_wr=0 and mem_size=2'd3.
REQ-022 Minimum latency req->data_ok SHALL be 3 cycles (grant, addr_ok, data_ok); no bypass from IDLE.
REQ-023 i_stall = i_req & ~i_data_ok; d_stall = d_req & ~d_data_ok (combinational).
REQ-024 mem_addr_ok and mem_data_ok in the same ADDR cycle: addr_ok SHALL be taken and data_ok ignored; the memory side guarantees data_ok arrives no earlier than the cycle after addr_ok.
REQ-025 *_rdata SHALL hold its value until that requester's next completion; stores SHALL leave d_rdata unchanged.

Configuration
REQ-026 Without ARB_ROUND_ROBIN_EN: fixed priority, d_req wins over i_req when both are pending in IDLE.
REQ-027 With ARB_ROUND_ROBIN_EN: a 1-bit last_owner register; on a tie the requester not served last is granted; last_owner resets to instruction, so data wins the first tie.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, mem_req=0, *_data_ok=0, *_rdata=0, and all latched request registers to 0, including mid-transaction.
REQ-029 After reset, a memory response belonging to an aborted transaction is discarded in IDLE.

Structure
REQ-030 The state encoding typedef and the owner constants OWN_I=1'b0 and OWN_D=1'b1 SHALL reside in the shared cpu package.
REQ-031 Grant selection SHALL be one sub-module, arb_pick2, combinational with the last_owner input used only under ARB_ROUND_ROBIN_EN.

Verification
REQ-032 A single i_req with addr 0x1FC00000, where addr_ok and data_ok each arrive 1 cycle later -> mem_req in cycle 1, i_data_ok in cycle 3, i_rdata = mem_rdata, and i_stall high in cycles 0-2.
REQ-033 i_req and d_req together, fixed priority -> d served first (mem_addr = d_addr), then i; i_stall stays high throughout.
REQ-034 Same stimulus with ARB_ROUND_ROBIN_EN and 4 back-to-back ties -> grants alternate D, I, D, I.
REQ-035 d_wr=1, d_size=0, wdata 0xA5 -> mem_wr=1, mem_size=0, mem_wdata=0xA5, and d_rdata unchanged.
REQ-036 rst asserted in DATA, followed by a stray mem_data_ok -> no *_data_ok pulse, state IDLE, all outputs 0.
